// File: rtl/cache_retire_ctrl.sv
// Three-entry cache valid/retire tracker: each entry walks INVALID -> VALID -> RETIRING -> INVALID,
// holding retire for RETIRE_HOLD cycles. Optional occupancy count under CACHE_RETIRE_CTRL_OCC_EN.
module cache_retire_ctrl #(
    parameter int NUM_ENTRIES = 3,
    parameter int RETIRE_HOLD = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   alloc_valid,
    input  logic [1:0]             alloc_addr,
    output logic                   alloc_ready,
    input  logic                   retire_req,
    input  logic [1:0]             retire_addr,
    output logic [NUM_ENTRIES-1:0] cache,
    output logic [NUM_ENTRIES-1:0] retire,
    output logic [NUM_ENTRIES-1:0] retire_done,
    output logic                   err
`ifdef CACHE_RETIRE_CTRL_OCC_EN
    ,
    output logic [1:0]             occ
`endif
);

    typedef enum logic [1:0] {
        ST_INVALID  = 2'd0,
        ST_VALID    = 2'd1,
        ST_RETIRING = 2'd2
    } state_t;

    state_t                 state_q [NUM_ENTRIES];
    state_t                 state_d [NUM_ENTRIES];
    logic [2:0]             hold_q  [NUM_ENTRIES];
    logic [2:0]             hold_d  [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] done_q, done_d;
    logic                   err_q, err_d;
    logic [NUM_ENTRIES-1:0] alloc_sel, retire_sel;
`ifdef CACHE_RETIRE_CTRL_OCC_EN
    logic [1:0]             occ_q, occ_d;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                state_q[i] <= ST_INVALID;
                hold_q[i]  <= 3'd0;
            end
            done_q <= '0;
            err_q  <= 1'b0;
`ifdef CACHE_RETIRE_CTRL_OCC_EN
            occ_q  <= 2'd0;
`endif
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                state_q[i] <= state_d[i];
                hold_q[i]  <= hold_d[i];
            end
            done_q <= done_d;
            err_q  <= err_d;
`ifdef CACHE_RETIRE_CTRL_OCC_EN
            occ_q  <= occ_d;
`endif
        end
    end

    // Address 3 matches no entry, so an out-of-range request can never be accepted.
    always_comb begin
        alloc_sel  = '0;
        retire_sel = '0;
        done_d     = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            alloc_sel[i]  = (alloc_addr == 2'(i)) && (state_q[i] == ST_INVALID);
            retire_sel[i] = retire_req && (retire_addr == 2'(i)) && (state_q[i] == ST_VALID);
            state_d[i]    = state_q[i];
            hold_d[i]     = hold_q[i];
            case (state_q[i])
                ST_INVALID: begin
                    if (alloc_valid && alloc_sel[i]) begin
                        state_d[i] = ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (retire_sel[i]) begin
                        state_d[i] = ST_RETIRING;
                        hold_d[i]  = 3'(RETIRE_HOLD - 1);
                    end
                end
                ST_RETIRING: begin
                    if (hold_q[i] == 3'd0) begin
                        state_d[i] = ST_INVALID;
                        done_d[i]  = 1'b1;
                    end else begin
                        hold_d[i]  = hold_q[i] - 3'd1;
                    end
                end
                default: begin
                    state_d[i] = ST_INVALID;
                    hold_d[i]  = 3'd0;
                end
            endcase
        end
        err_d = (alloc_valid && !(|alloc_sel)) || (retire_req && !(|retire_sel));
    end

`ifdef CACHE_RETIRE_CTRL_OCC_EN
    always_comb begin
        occ_d = 2'd0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            occ_d = occ_d + 2'(state_d[i] != ST_INVALID);
        end
    end
    assign occ = occ_q;
`endif

    always_comb begin
        cache  = '0;
        retire = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            cache[i]  = (state_q[i] != ST_INVALID);
            retire[i] = (state_q[i] == ST_RETIRING);
        end
        alloc_ready = |alloc_sel;
        retire_done = done_q;
        err         = err_q;
    end

endmodule
